// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//
// Flip-flop register file with two independent registered read ports and one
// write port. Sits between decode and the ALU operand muxes, delivering two
// operands per cycle.
//
// A read issued in the same cycle as a write to the same address returns the
// new write data (write-to-read bypass). When ZERO_REG is set, entry 0 is
// hardwired to zero: writes to it are dropped and reads of it return 0.
//
// Parameters:
//   DWIDTH   data width in bits (>= 1)
//   AWIDTH   address width; depth is 2**AWIDTH entries
//   ZERO_REG 1 = entry 0 reads as zero and ignores writes
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; clears storage and outputs
//   wen            write enable
//   waddr, wdata   write address / data
//   ren0, raddr0   read enable / address, port 0
//   rdata0         registered read data, port 0 (holds while ren0 = 0)
//   ren1, raddr1   read enable / address, port 1
//   rdata1         registered read data, port 1 (holds while ren1 = 0)
// -----------------------------------------------------------------------------
module regfile_2r1w #(
   parameter int unsigned DWIDTH   = 8,
   parameter int unsigned AWIDTH   = 3,
   parameter bit          ZERO_REG = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wen,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              ren0,
   input  logic [AWIDTH-1:0] raddr0,
   output logic [DWIDTH-1:0] rdata0,
   input  logic              ren1,
   input  logic [AWIDTH-1:0] raddr1,
   output logic [DWIDTH-1:0] rdata1
);

   localparam int DEPTH = 32'sd1 <<< AWIDTH;

   // Storage and registered read data
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] mem_d [DEPTH];
   logic [DWIDTH-1:0] rdata0_q;
   logic [DWIDTH-1:0] rdata0_d;
   logic [DWIDTH-1:0] rdata1_q;
   logic [DWIDTH-1:0] rdata1_d;

   // Combinational helpers
   logic              wr_en_eff;
   logic [DWIDTH-1:0] rsel0;
   logic [DWIDTH-1:0] rsel1;

   // Read-value selection shared by both ports so that two ports reading the
   // same address always see the identical value, bypass included.
   // Priority: hardwired zero, then same-cycle write data, then stored entry.
   function automatic logic [DWIDTH-1:0] read_select(
      input logic [AWIDTH-1:0] ra,
      input logic [DWIDTH-1:0] stored,
      input logic              w_en,
      input logic [AWIDTH-1:0] w_addr,
      input logic [DWIDTH-1:0] w_data
   );
      logic [DWIDTH-1:0] val;
      if (ZERO_REG && (ra == {AWIDTH{1'b0}})) begin
         val = {DWIDTH{1'b0}};
      end else if (w_en && (w_addr == ra)) begin
         val = w_data;
      end else begin
         val = stored;
      end
      return val;
   endfunction

   // Effective write enable: a write to the hardwired zero entry is dropped
   always_comb begin
      wr_en_eff = 1'b0;
      if (wen) begin
         if (ZERO_REG && (waddr == {AWIDTH{1'b0}})) begin
            wr_en_eff = 1'b0;
         end else begin
            wr_en_eff = 1'b1;
         end
      end else begin
         wr_en_eff = 1'b0;
      end
   end

   // Next-state of the storage array: only the addressed entry takes wdata
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en_eff && (waddr == AWIDTH'(i))) begin
            mem_d[i] = wdata;
         end else begin
            mem_d[i] = mem_q[i];
         end
      end
   end

   // Read selection for both ports from the pre-edge storage contents
   always_comb begin
      rsel0 = read_select(raddr0, mem_q[raddr0], wen, waddr, wdata);
      rsel1 = read_select(raddr1, mem_q[raddr1], wen, waddr, wdata);
   end

   // Read data next-state: load on enable, otherwise hold
   always_comb begin
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      if (ren0) begin
         rdata0_d = rsel0;
      end else begin
         rdata0_d = rdata0_q;
      end
      if (ren1) begin
         rdata1_d = rsel1;
      end else begin
         rdata1_d = rdata1_q;
      end
   end

   // State registers; reset clears storage and outputs without a clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DWIDTH{1'b0}};
         end
         rdata0_q <= {DWIDTH{1'b0}};
         rdata1_q <= {DWIDTH{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
//
// Self-checking bench for regfile_2r1w. Three instances share clock and reset:
//   dut   default 8x8, ZERO_REG = 0 (table-driven vectors + reset sequence)
//   dut_z 8x8 with ZERO_REG = 1   (hand-written zero-entry sequence)
//   dut_w 32-bit data, 32 entries (hand-written parametrisation sequence)
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_2r1w;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // Default instance signals
   logic       wen, ren0, ren1;
   logic [2:0] waddr, raddr0, raddr1;
   logic [7:0] wdata, rdata0, rdata1;

   // Zero-register instance signals
   logic       z_wen, z_ren0, z_ren1;
   logic [2:0] z_waddr, z_raddr0, z_raddr1;
   logic [7:0] z_wdata, z_rdata0, z_rdata1;

   // Wide instance signals
   logic        w_wen, w_ren0, w_ren1;
   logic [4:0]  w_waddr, w_raddr0, w_raddr1;
   logic [31:0] w_wdata, w_rdata0, w_rdata1;

   regfile_2r1w dut (
      .clk(clk), .rst_n(rst_n),
      .wen(wen), .waddr(waddr), .wdata(wdata),
      .ren0(ren0), .raddr0(raddr0), .rdata0(rdata0),
      .ren1(ren1), .raddr1(raddr1), .rdata1(rdata1)
   );

   regfile_2r1w #(.DWIDTH(8), .AWIDTH(3), .ZERO_REG(1'b1)) dut_z (
      .clk(clk), .rst_n(rst_n),
      .wen(z_wen), .waddr(z_waddr), .wdata(z_wdata),
      .ren0(z_ren0), .raddr0(z_raddr0), .rdata0(z_rdata0),
      .ren1(z_ren1), .raddr1(z_raddr1), .rdata1(z_rdata1)
   );

   regfile_2r1w #(.DWIDTH(32), .AWIDTH(5), .ZERO_REG(1'b0)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .wen(w_wen), .waddr(w_waddr), .wdata(w_wdata),
      .ren0(w_ren0), .raddr0(w_raddr0), .rdata0(w_rdata0),
      .ren1(w_ren1), .raddr1(w_raddr1), .rdata1(w_rdata1)
   );

   typedef struct {
      string      name;
      logic       wen;
      logic [2:0] waddr;
      logic [7:0] wdata;
      logic       ren0;
      logic [2:0] raddr0;
      logic       ren1;
      logic [2:0] raddr1;
      logic       chk;
      logic [7:0] exp0;
      logic [7:0] exp1;
   } vec_t;

   vec_t vecs[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   function automatic vec_t mk(input string nm,
                               input logic we, input logic [2:0] wa, input logic [7:0] wd,
                               input logic r0, input logic [2:0] a0,
                               input logic r1, input logic [2:0] a1,
                               input logic ck, input logic [7:0] e0, input logic [7:0] e1);
      vec_t v;
      v.name = nm; v.wen = we; v.waddr = wa; v.wdata = wd;
      v.ren0 = r0; v.raddr0 = a0; v.ren1 = r1; v.raddr1 = a1;
      v.chk = ck; v.exp0 = e0; v.exp1 = e1;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic r0, input logic [2:0] a0,
                        input logic r1, input logic [2:0] a1);
      wen = we; waddr = wa; wdata = wd;
      ren0 = r0; raddr0 = a0; ren1 = r1; raddr1 = a1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
      z_wen = 1'b0; z_waddr = 3'd0; z_wdata = 8'h00;
      z_ren0 = 1'b0; z_raddr0 = 3'd0; z_ren1 = 1'b0; z_raddr1 = 3'd0;
      w_wen = 1'b0; w_waddr = 5'd0; w_wdata = 32'h0;
      w_ren0 = 1'b0; w_raddr0 = 5'd0; w_ren1 = 1'b0; w_raddr1 = 5'd0;

      // ---------------- Reset state ----------------
      #12;
      check("reset_rdata0",   32'(rdata0),   32'h0);
      check("reset_rdata1",   32'(rdata1),   32'h0);
      check("reset_z_rdata0", 32'(z_rdata0), 32'h0);
      check("reset_w_rdata1", w_rdata1,      32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- Vector table ----------------
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk("fill", 1'b1, 3'(i), 8'(8'h11 * (i + 1)),
                           1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00));
      end
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk("basic_rd", 1'b0, 3'd0, 8'h00,
                           1'b1, 3'(i), 1'b1, 3'(7 - i),
                           1'b1, 8'(8'h11 * (i + 1)), 8'(8'h11 * (8 - i))));
      end
      vecs.push_back(mk("byp_pre",   1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00));
      vecs.push_back(mk("bypass",    1'b1, 3'd5, 8'hC3, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 8'hC3, 8'hC3));
      vecs.push_back(mk("byp_after", 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 1'b1, 3'd2, 1'b1, 8'hC3, 8'h33));
      vecs.push_back(mk("byp_after", 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd5, 1'b1, 8'h11, 8'hC3));
      vecs.push_back(mk("hold_pre",  1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 8'h22, 8'h33));
      vecs.push_back(mk("hold_wr",   1'b1, 3'd1, 8'h99, 1'b0, 3'd1, 1'b0, 3'd1, 1'b1, 8'h22, 8'h33));
      vecs.push_back(mk("hold_idle", 1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 1'b0, 3'd1, 1'b1, 8'h22, 8'h33));
      vecs.push_back(mk("hold_rd",   1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0, 3'd1, 1'b1, 8'h99, 8'h33));
      vecs.push_back(mk("b2b_wr1",   1'b1, 3'd6, 8'h01, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00));
      vecs.push_back(mk("b2b_wr2",   1'b1, 3'd6, 8'h02, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00));
      vecs.push_back(mk("b2b_rd",    1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 8'h02, 8'h02));
      vecs.push_back(mk("byp_other", 1'b1, 3'd4, 8'hEE, 1'b1, 3'd3, 1'b1, 3'd4, 1'b1, 8'h44, 8'hEE));
      vecs.push_back(mk("rd_after",  1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd3, 1'b1, 8'hEE, 8'h44));
      vecs.push_back(mk("byp_p0",    1'b1, 3'd7, 8'h70, 1'b1, 3'd7, 1'b1, 3'd6, 1'b1, 8'h70, 8'h02));
      vecs.push_back(mk("wen_off",   1'b0, 3'd7, 8'hAB, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1, 8'h70, 8'h70));

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k].wen, vecs[k].waddr, vecs[k].wdata,
               vecs[k].ren0, vecs[k].raddr0, vecs[k].ren1, vecs[k].raddr1);
         @(posedge clk);
         #1;
         if (vecs[k].chk) begin
            check({vecs[k].name, "_rdata0"}, 32'(rdata0), 32'(vecs[k].exp0));
            check({vecs[k].name, "_rdata1"}, 32'(rdata1), 32'(vecs[k].exp1));
         end
      end

      // ---------------- Mid-run reset ----------------
      @(negedge clk);
      drive(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0);
      @(negedge clk);
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3);
      @(posedge clk);
      #1;
      check("rst_pre_rdata0", 32'(rdata0), 32'hA5);
      check("rst_pre_rdata1", 32'(rdata1), 32'hA5);
      #1;
      rst_n = 1'b0;                 // asynchronous assertion between edges
      #1;
      check("rst_async_rdata0", 32'(rdata0), 32'h0);
      check("rst_async_rdata1", 32'(rdata1), 32'h0);
      @(negedge clk);
      drive(1'b1, 3'd3, 8'h77, 1'b1, 3'd3, 1'b1, 3'd3);
      @(posedge clk);
      #1;
      check("rst_hold_rdata0", 32'(rdata0), 32'h0);
      check("rst_hold_rdata1", 32'(rdata1), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3);
      @(posedge clk);
      #1;
      check("rst_after_rdata0", 32'(rdata0), 32'h0);
      check("rst_after_rdata1", 32'(rdata1), 32'h0);

      // ---------------- Zero register instance ----------------
      @(negedge clk);
      z_wen = 1'b1; z_waddr = 3'd0; z_wdata = 8'hFF; z_ren0 = 1'b0; z_ren1 = 1'b0;
      @(negedge clk);
      z_wen = 1'b0; z_ren0 = 1'b1; z_raddr0 = 3'd0; z_ren1 = 1'b1; z_raddr1 = 3'd0;
      @(posedge clk);
      #1;
      check("zero_rd_rdata0", 32'(z_rdata0), 32'h0);
      check("zero_rd_rdata1", 32'(z_rdata1), 32'h0);
      @(negedge clk);
      z_wen = 1'b1; z_waddr = 3'd0; z_wdata = 8'hFF;
      @(posedge clk);
      #1;
      check("zero_byp_rdata0", 32'(z_rdata0), 32'h0);
      check("zero_byp_rdata1", 32'(z_rdata1), 32'h0);
      @(negedge clk);
      z_wen = 1'b1; z_waddr = 3'd1; z_wdata = 8'h5A; z_raddr0 = 3'd0; z_raddr1 = 3'd1;
      @(posedge clk);
      #1;
      check("zero_nz_rdata0", 32'(z_rdata0), 32'h0);
      check("zero_nz_rdata1", 32'(z_rdata1), 32'h5A);
      @(negedge clk);
      z_wen = 1'b0; z_raddr0 = 3'd1; z_raddr1 = 3'd0;
      @(posedge clk);
      #1;
      check("zero_st_rdata0", 32'(z_rdata0), 32'h5A);
      check("zero_st_rdata1", 32'(z_rdata1), 32'h0);

      // ---------------- Wide instance ----------------
      @(negedge clk);
      w_wen = 1'b1; w_waddr = 5'd31; w_wdata = 32'hDEADBEEF;
      @(negedge clk);
      w_waddr = 5'd0; w_wdata = 32'h00000001;
      @(negedge clk);
      w_wen = 1'b0; w_ren0 = 1'b1; w_raddr0 = 5'd31; w_ren1 = 1'b1; w_raddr1 = 5'd0;
      @(posedge clk);
      #1;
      check("wide_rdata0", w_rdata0, 32'hDEADBEEF);
      check("wide_rdata1", w_rdata1, 32'h00000001);
      @(negedge clk);
      w_raddr0 = 5'd0; w_raddr1 = 5'd31;
      @(posedge clk);
      #1;
      check("wide_sw_rdata0", w_rdata0, 32'h00000001);
      check("wide_sw_rdata1", w_rdata1, 32'hDEADBEEF);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
